// File: rtl/sprite_line_fetcher.sv
// Per-pixel print controller: looks up the sprite under each accepted pixel,
// then emits either the background address or a full sprite line of addresses.
module sprite_line_fetcher #(
  parameter int unsigned SIZE_X         = 10,
  parameter int unsigned SIZE_Y         = 9,
  parameter int unsigned SIZE_ADDRESS   = 17,
  parameter int unsigned SPRITE_DIM     = 20,
  parameter int unsigned SCREEN_X       = 480,
  parameter int unsigned SCREEN_Y       = 320,
  parameter int unsigned BG_ADDRESS     = 115200,
  parameter logic [31:0] BG_CODE        = 32'h00000001,
  parameter int unsigned BG_HOLD        = 2,
  parameter int unsigned LOOKUP_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     active_area,
  input  logic [SIZE_X-1:0]        pixel_x,
  input  logic [SIZE_Y-1:0]        pixel_y,
  input  logic                     pixel_valid,
  output logic                     busy,
  output logic [SIZE_X+SIZE_Y-1:0] check_value,
  output logic                     check_valid,
  input  logic [31:0]              data_reg,
  input  logic                     data_valid,
  output logic [SIZE_ADDRESS-1:0]  memory_address,
  output logic                     mem_valid,
  output logic                     sprite_on,
  output logic [31:0]              sprite_datas,
  output logic                     printing_screen,
  output logic                     lookup_error
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    DECIDE,
    BG,
    SPRITE
  } state_t;

  state_t      state;
  logic [31:0] data_q;
  logic [15:0] tcnt;
  logic [15:0] cnt;
  logic        in_screen;

  assign in_screen = (32'(pixel_x) < SCREEN_X) && (32'(pixel_y) < SCREEN_Y);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      data_q          <= '0;
      tcnt            <= '0;
      cnt             <= '0;
      busy            <= 1'b0;
      check_value     <= '0;
      check_valid     <= 1'b0;
      memory_address  <= '0;
      mem_valid       <= 1'b0;
      sprite_on       <= 1'b0;
      sprite_datas    <= '0;
      printing_screen <= 1'b0;
      lookup_error    <= 1'b0;
    end else begin
      lookup_error <= 1'b0;
      if (state != IDLE && !active_area) begin
        state       <= IDLE;
        busy        <= 1'b0;
        check_valid <= 1'b0;
        mem_valid   <= 1'b0;
        sprite_on   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (pixel_valid) begin
              if (in_screen && active_area) begin
                check_value     <= {pixel_x, pixel_y};
                check_valid     <= 1'b1;
                printing_screen <= 1'b1;
                busy            <= 1'b1;
                tcnt            <= '0;
                state           <= LOOKUP;
              end else if (!in_screen) begin
                printing_screen <= 1'b0;
              end
            end
          end
          LOOKUP: begin
            if (data_valid) begin
              data_q      <= data_reg;
              check_valid <= 1'b0;
              state       <= DECIDE;
            end else if (tcnt == 16'(LOOKUP_TIMEOUT - 1)) begin
              // Timed-out lookup is treated as background one cycle later
              lookup_error <= 1'b1;
              data_q       <= BG_CODE;
              check_valid  <= 1'b0;
              state        <= DECIDE;
            end else begin
              tcnt <= tcnt + 16'd1;
            end
          end
          DECIDE: begin
            mem_valid <= 1'b1;
            cnt       <= '0;
            if (data_q == BG_CODE) begin
              memory_address <= SIZE_ADDRESS'(BG_ADDRESS);
              state          <= BG;
            end else begin
              memory_address <= data_q[SIZE_ADDRESS-1:0];
              sprite_datas   <= data_q;
              sprite_on      <= 1'b1;
              state          <= SPRITE;
            end
          end
          BG: begin
            if (cnt == 16'(BG_HOLD - 1)) begin
              mem_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          SPRITE: begin
            if (cnt == 16'(SPRITE_DIM - 1)) begin
              mem_valid <= 1'b0;
              sprite_on <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt            <= cnt + 16'd1;
              memory_address <= memory_address + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Scoreboard bench for sprite_line_fetcher: expected address stream is queued
// at issue time and popped by a monitor whenever mem_valid is high.
module tb_sprite_line_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        active_area;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        pixel_valid;
  logic        busy;
  logic [18:0] check_value;
  logic        check_valid;
  logic [31:0] data_reg;
  logic        data_valid;
  logic [16:0] memory_address;
  logic        mem_valid;
  logic        sprite_on;
  logic [31:0] sprite_datas;
  logic        printing_screen;
  logic        lookup_error;

  sprite_line_fetcher dut (
    .clk(clk), .reset(reset), .active_area(active_area),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .busy(busy), .check_value(check_value), .check_valid(check_valid),
    .data_reg(data_reg), .data_valid(data_valid),
    .memory_address(memory_address), .mem_valid(mem_valid),
    .sprite_on(sprite_on), .sprite_datas(sprite_datas),
    .printing_screen(printing_screen), .lookup_error(lookup_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] addr;
    logic        spr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset && mem_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_mem", {15'd0, memory_address}, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mem_addr", {15'd0, memory_address}, {15'd0, e.addr});
        chk("mem_sprite_on", {31'd0, sprite_on}, {31'd0, e.spr});
      end
    end
  end

  task automatic push_exp(input logic [31:0] data, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (data == 32'h1) begin
        e.addr = 17'd115200;
        e.spr  = 1'b0;
      end else begin
        e.addr = data[16:0] + 17'(i);
        e.spr  = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  task automatic offer(input logic [9:0] x, input logic [8:0] y);
    @(negedge clk);
    pixel_x = x;
    pixel_y = y;
    pixel_valid = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  task automatic run(input logic [9:0] x, input logic [8:0] y, input int k,
                     input logic [31:0] data, input int nmem, input bit inject);
    int n;
    int t;
    bit err;
    err = 1'b0;
    push_exp(data, nmem);
    offer(x, y);
    chk("check_valid", {31'd0, check_valid}, 32'd1);
    chk("check_value", {13'd0, check_value}, {13'd0, x, y});
    chk("busy_accept", {31'd0, busy}, 32'd1);
    chk("printing_screen", {31'd0, printing_screen}, 32'd1);
    for (int i = 1; i < k; i++) begin
      if (lookup_error) err = 1'b1;
      @(negedge clk);
    end
    data_reg = data;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("latency_lo", {31'd0, mem_valid}, 32'd0);
    if (lookup_error) err = 1'b1;
    @(negedge clk);
    chk("latency_hi", {31'd0, mem_valid}, 32'd1);
    if (data != 32'h1) chk("sprite_datas", sprite_datas, data);
    n = 0;
    t = 0;
    while (busy && t < 400) begin
      if (mem_valid) n++;
      if (lookup_error) err = 1'b1;
      if (inject && n == 3) begin
        pixel_x = 10'd1;
        pixel_y = 9'd1;
        pixel_valid = 1'b1;
      end else begin
        pixel_valid = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    pixel_valid = 1'b0;
    chk("busy_drop", {31'd0, busy}, 32'd0);
    chk("mem_count", n, nmem);
    chk("busy_len", t, nmem);
    chk("no_error", {31'd0, err}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_check_valid"}, {31'd0, check_valid}, 32'd0);
    chk({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
    chk({tag, "_sprite_on"}, {31'd0, sprite_on}, 32'd0);
    chk({tag, "_printing"}, {31'd0, printing_screen}, 32'd0);
    chk({tag, "_lookup_error"}, {31'd0, lookup_error}, 32'd0);
    chk({tag, "_check_value"}, {13'd0, check_value}, 32'd0);
    chk({tag, "_mem_addr"}, {15'd0, memory_address}, 32'd0);
    chk({tag, "_sprite_datas"}, sprite_datas, 32'd0);
  endtask

  task automatic stream_until(input int target);
    int n;
    int t;
    n = 0;
    t = 0;
    @(negedge clk);
    while (n < target && t < 60) begin
      @(negedge clk);
      t++;
      if (mem_valid) n++;
    end
    chk("stream_reached", n, target);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    active_area = 1'b1;
    pixel_x = '0;
    pixel_y = '0;
    pixel_valid = 1'b0;
    data_reg = '0;
    data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    run(10'd5, 9'd7, 1, 32'h1, 2, 1'b0);
    run(10'd10, 9'd10, 1, 32'h400, 20, 1'b1);
    run(10'd200, 9'd100, 1, 32'h0001FFFE, 20, 1'b0);

    // lookup timeout
    push_exp(32'h1, 2);
    offer(10'd20, 9'd30);
    n = 0;
    while (!lookup_error && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycle", n, 15);
    @(negedge clk);
    chk("error_pulse", {31'd0, lookup_error}, 32'd0);
    chk("timeout_bg", {31'd0, mem_valid}, 32'd1);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_idle", {31'd0, busy}, 32'd0);

    run(10'd40, 9'd40, 15, 32'h100, 20, 1'b0);

    // out-of-screen pixels
    offer(10'd480, 9'd0);
    chk("oos_x_print", {31'd0, printing_screen}, 32'd0);
    chk("oos_x_busy", {31'd0, busy}, 32'd0);
    run(10'd479, 9'd319, 1, 32'h1, 2, 1'b0);
    offer(10'd0, 9'd320);
    chk("oos_y_print", {31'd0, printing_screen}, 32'd0);
    chk("oos_y_check", {31'd0, check_valid}, 32'd0);

    // abort on blanking at the 5th sprite address
    push_exp(32'h800, 5);
    offer(10'd100, 9'd100);
    data_reg = 32'h800;
    data_valid = 1'b1;
    stream_until(5);
    data_valid = 1'b0;
    active_area = 1'b0;
    @(negedge clk);
    active_area = 1'b1;
    chk("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("abort_sprite_on", {31'd0, sprite_on}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_error", {31'd0, lookup_error}, 32'd0);

    run(10'd1, 9'd2, 2, 32'h1, 2, 1'b0);

    // asynchronous reset mid-sprite
    push_exp(32'h900, 3);
    offer(10'd3, 9'd4);
    data_reg = 32'h900;
    data_valid = 1'b1;
    stream_until(3);
    data_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
